// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing the single memory line port between the icache
// (read-only) and the dcache (read/write); one blocking transaction at a time.
module mem_request_arbiter #(
   parameter int PHYSICAL_ADDR_WIDTH = 32,
   parameter int LINE_WIDTH          = 128,
   parameter int LINE_ADDR_WIDTH     = PHYSICAL_ADDR_WIDTH - $clog2(LINE_WIDTH/8)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ic_read,
   input  logic [LINE_ADDR_WIDTH-1:0] ic_line_addr,
   output logic                       ic_resp_valid,
   output logic [LINE_WIDTH-1:0]      ic_resp_data,
   input  logic                       dc_read,
   input  logic                       dc_write,
   input  logic [LINE_ADDR_WIDTH-1:0] dc_line_addr,
   input  logic [LINE_WIDTH-1:0]      dc_line_data,
   output logic                       dc_resp_valid,
   output logic [LINE_WIDTH-1:0]      dc_resp_data,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [LINE_ADDR_WIDTH-1:0] mem_line_addr,
   output logic [LINE_WIDTH-1:0]      mem_line_data,
   input  logic                       mem_resp_valid,
   input  logic [LINE_WIDTH-1:0]      mem_resp_data,
   output logic                       busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                     state_q, state_d;
   logic                       last_dc_q;   // 1: dcache won the previous grant
   logic                       grant_dc_q;
   logic                       wr_q;
   logic [LINE_ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0]      data_q;
   logic [LINE_WIDTH-1:0]      resp_q;

   logic ic_req, dc_req, grant, grant_dc;

   assign ic_req = ic_read;
   assign dc_req = dc_read | dc_write;

   always_comb begin
      state_d  = state_q;
      grant    = 1'b0;
      grant_dc = 1'b0;
      case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               grant    = 1'b1;
               // on a tie the cache that did not win last time goes first
               grant_dc = dc_req && (!ic_req || !last_dc_q);
               state_d  = ISSUE;
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    if (mem_resp_valid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_dc_q  <= 1'b0;
         grant_dc_q <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         resp_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            grant_dc_q <= grant_dc;
            last_dc_q  <= grant_dc;
            wr_q       <= grant_dc & dc_write;
            addr_q     <= grant_dc ? dc_line_addr : ic_line_addr;
            data_q     <= grant_dc ? dc_line_data : '0;
         end
         if (state_q == WAIT && mem_resp_valid)
            resp_q <= mem_resp_data;
      end
   end

   // all outputs decode from registered state, so IDLE forces them to zero
   always_comb begin
      mem_read      = (state_q == ISSUE) && !wr_q;
      mem_write     = (state_q == ISSUE) &&  wr_q;
      mem_line_addr = (state_q != IDLE) ? addr_q : '0;
      mem_line_data = (state_q != IDLE) ? data_q : '0;
      ic_resp_valid = (state_q == RESP) && !grant_dc_q;
      dc_resp_valid = (state_q == RESP) &&  grant_dc_q;
      ic_resp_data  = ic_resp_valid ? resp_q : '0;
      dc_resp_data  = dc_resp_valid ? resp_q : '0;
      busy          = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: directed transactions push expected strobes/responses,
// a negedge monitor pops and compares whenever the arbiter presents them.
module tb_mem_request_arbiter;

   localparam int LW = 128;
   localparam int AW = 28;

   typedef struct {
      bit            is_dc;
      bit            chk_data;
      logic [LW-1:0] data;
      int            cyc;
   } resp_t;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      int            cyc;
   } memx_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ic_read = 1'b0;
   logic [AW-1:0] ic_line_addr = '0;
   logic          ic_resp_valid;
   logic [LW-1:0] ic_resp_data;
   logic          dc_read = 1'b0;
   logic          dc_write = 1'b0;
   logic [AW-1:0] dc_line_addr = '0;
   logic [LW-1:0] dc_line_data = '0;
   logic          dc_resp_valid;
   logic [LW-1:0] dc_resp_data;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_line_addr;
   logic [LW-1:0] mem_line_data;
   logic          mem_resp_valid = 1'b0;
   logic [LW-1:0] mem_resp_data = '0;
   logic          busy;

   mem_request_arbiter dut (
      .clk(clk), .reset(reset),
      .ic_read(ic_read), .ic_line_addr(ic_line_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_read(dc_read), .dc_write(dc_write), .dc_line_addr(dc_line_addr),
      .dc_line_data(dc_line_data), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_line_addr(mem_line_addr),
      .mem_line_data(mem_line_data), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   resp_t         exp_resp[$];
   memx_t         exp_mem[$];
   logic [LW-1:0] mem_data_q[$];

   task automatic chk(input bit ok, input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, req);
      end
   endtask

   // memory model: auto mode answers each strobe after mem_lat cycles,
   // manual mode pulses mem_resp_valid whenever the main thread asks
   bit            auto_mem = 1'b1;
   int            mem_lat = 1;
   bit            man_pulse = 1'b0;
   logic [LW-1:0] mem_rdata = '0;
   bit            seen_rd = 1'b0, seen_wr = 1'b0;
   int            mem_cnt = 0;
   logic [LW-1:0] cur_data = '0;

   always @(negedge clk) begin
      seen_rd = mem_read;
      seen_wr = mem_write;
   end

   always @(posedge clk) begin
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (auto_mem) begin
         if (seen_rd || seen_wr) begin
            mem_cnt  = mem_lat;
            cur_data = '0;
            if (seen_rd && mem_data_q.size() > 0) cur_data = mem_data_q.pop_front();
         end
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = cur_data;
            end
         end
      end else if (man_pulse) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = mem_rdata;
      end
   end

   // monitor
   bit mon_en = 1'b0;
   bit prev_strobe = 1'b0;
   always @(negedge clk) begin
      memx_t m;
      resp_t r;
      bit    strobe;
      if (mon_en) begin
         strobe = mem_read || mem_write;
         chk(!(mem_read && mem_write), "rw_exclusive", {mem_read, mem_write}, 0);
         if (strobe) begin
            chk(!prev_strobe, "strobe_gap", 1, 0);
            if (exp_mem.size() == 0) chk(0, "unexpected_strobe", {mem_read, mem_write}, 0);
            else begin
               m = exp_mem.pop_front();
               chk(mem_write == m.wr, "mem_op_write", mem_write, m.wr);
               chk(mem_line_addr == m.addr, "mem_addr", mem_line_addr, m.addr);
               if (m.wr) chk(mem_line_data == m.data, "mem_data", mem_line_data, m.data);
               chk(cyc == m.cyc, "strobe_cycle", cyc, m.cyc);
            end
         end
         prev_strobe = strobe;
         if (ic_resp_valid || dc_resp_valid) begin
            chk(!(ic_resp_valid && dc_resp_valid), "resp_both", 1, 0);
            if (exp_resp.size() == 0) chk(0, "unexpected_resp", {ic_resp_valid, dc_resp_valid}, 0);
            else begin
               r = exp_resp.pop_front();
               chk(dc_resp_valid == r.is_dc, "resp_owner_dc", dc_resp_valid, r.is_dc);
               chk(cyc == r.cyc, "resp_cycle", cyc, r.cyc);
               if (r.chk_data)
                  chk((r.is_dc ? dc_resp_data : ic_resp_data) == r.data, "resp_data",
                      r.is_dc ? dc_resp_data : ic_resp_data, r.data);
            end
         end
         if (!ic_resp_valid) chk(ic_resp_data == '0, "ic_data_quiet", ic_resp_data, 0);
         if (!dc_resp_valid) chk(dc_resp_data == '0, "dc_data_quiet", dc_resp_data, 0);
      end
   end

   task automatic chk_idle(input string nm);
      chk({ic_resp_valid, dc_resp_valid, mem_read, mem_write, busy} == 5'b0, {nm, "_ctl"},
          {ic_resp_valid, dc_resp_valid, mem_read, mem_write, busy}, 0);
      chk(mem_line_addr == '0, {nm, "_addr"}, mem_line_addr, 0);
      chk(mem_line_data == '0 && ic_resp_data == '0 && dc_resp_data == '0, {nm, "_data"},
          mem_line_data | ic_resp_data | dc_resp_data, 0);
   endtask

   // called just after a negedge in IDLE; returns just after the IDLE negedge following RESP
   task automatic run_txn(input bit dc, input bit wr, input bit rd, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata, input int lat);
      memx_t m;
      resp_t r;
      bit    got = 1'b0;
      int    j = cyc;
      mem_lat = lat;
      if (!wr) mem_data_q.push_back(rdata);
      m.wr = wr; m.addr = addr; m.data = wdata; m.cyc = j + 1;
      exp_mem.push_back(m);
      r.is_dc = dc; r.chk_data = !wr; r.data = rdata; r.cyc = j + lat + 2;
      exp_resp.push_back(r);
      if (dc) begin
         dc_read = rd; dc_write = wr; dc_line_addr = addr; dc_line_data = wdata;
      end else begin
         ic_read = 1'b1; ic_line_addr = addr;
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (dc ? dc_resp_valid : ic_resp_valid) begin
            got = 1'b1;
            break;
         end
      end
      ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
      if (!got) chk(0, "txn_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && (exp_resp.size() + exp_mem.size()) > 0; c++) @(negedge clk);
      if ((exp_resp.size() + exp_mem.size()) > 0) begin
         chk(0, "scoreboard_drain", exp_resp.size() + exp_mem.size(), 0);
         exp_resp.delete();
         exp_mem.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      memx_t m;
      resp_t r;
      int    j, ndc, nic, idle_cnt;
      bit    rearm_dc, rearm_ic;

      repeat (3) @(negedge clk);
      chk_idle("reset_state");
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // single icache read, memory latency 2 -> response 4 cycles after request
      run_txn(0, 0, 1, 28'h0000123, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 2);
      // dcache write, latency 1 -> ack 3 cycles after request
      run_txn(1, 1, 0, 28'h00000A0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, '0, 1);
      // read and write together: only the write reaches memory
      run_txn(1, 1, 1, 28'h00000B7, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, '0, 2);
      // dcache read, latency 3
      run_txn(1, 0, 1, 28'hFFFFFFF, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3);
      drain();

      // stray responses in IDLE and ISSUE are ignored; real one at WAIT+3
      auto_mem = 1'b0;
      mem_rdata = 128'h5555_AAAA_5555_AAAA_0000_1111_2222_3333;
      man_pulse = 1'b1;
      @(negedge clk);
      man_pulse = 1'b0;
      @(negedge clk);
      j = cyc;
      m.wr = 0; m.addr = 28'h0ABCDEF; m.data = '0; m.cyc = j + 1;
      exp_mem.push_back(m);
      r.is_dc = 0; r.chk_data = 1; r.data = mem_rdata; r.cyc = j + 6;
      exp_resp.push_back(r);
      ic_read = 1'b1; ic_line_addr = 28'h0ABCDEF;
      man_pulse = 1'b1;
      @(negedge clk);
      man_pulse = 1'b0;
      repeat (3) @(negedge clk);
      man_pulse = 1'b1;
      @(negedge clk);
      man_pulse = 1'b0;
      @(negedge clk);
      chk(ic_resp_valid, "stray_resp_at_wait3", ic_resp_valid, 1);
      ic_read = 1'b0;
      @(negedge clk);
      drain();

      // reset while in WAIT: aborted request produces nothing
      j = cyc;
      m.wr = 0; m.addr = 28'h0000777; m.data = '0; m.cyc = j + 1;
      exp_mem.push_back(m);
      dc_read = 1'b1; dc_line_addr = 28'h0000777;
      repeat (2) @(negedge clk);
      chk(busy, "busy_in_wait", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk_idle("after_reset");
      reset = 1'b0;
      dc_read = 1'b0;
      man_pulse = 1'b1;
      @(negedge clk);
      man_pulse = 1'b0;
      chk(!busy, "busy_late_resp", busy, 0);
      @(negedge clk);
      chk_idle("late_resp_ignored");
      drain();

      // contention from reset: DC must win first, then strict alternation
      auto_mem = 1'b1;
      mem_lat = 1;
      mem_data_q.push_back(128'hD0D0_0000_0000_0000_0000_0000_0000_0001);
      mem_data_q.push_back(128'h1C1C_0000_0000_0000_0000_0000_0000_0002);
      mem_data_q.push_back(128'hD0D0_0000_0000_0000_0000_0000_0000_0003);
      mem_data_q.push_back(128'h1C1C_0000_0000_0000_0000_0000_0000_0004);
      j = cyc;
      for (int i = 0; i < 4; i++) begin
         m.wr = 0; m.addr = (i % 2 == 0) ? 28'h0000D00 : 28'h0000100; m.data = '0;
         m.cyc = j + 1 + 4 * i;
         exp_mem.push_back(m);
         r.is_dc = (i % 2 == 0); r.chk_data = 1; r.cyc = j + 3 + 4 * i;
         r.data = (i == 0) ? 128'hD0D0_0000_0000_0000_0000_0000_0000_0001 :
                  (i == 1) ? 128'h1C1C_0000_0000_0000_0000_0000_0000_0002 :
                  (i == 2) ? 128'hD0D0_0000_0000_0000_0000_0000_0000_0003 :
                             128'h1C1C_0000_0000_0000_0000_0000_0000_0004;
         exp_resp.push_back(r);
      end
      dc_read = 1'b1; dc_line_addr = 28'h0000D00;
      ic_read = 1'b1; ic_line_addr = 28'h0000100;
      ndc = 0; nic = 0; idle_cnt = 0; rearm_dc = 0; rearm_ic = 0;
      for (int c = 0; c < 80 && (ndc + nic) < 4; c++) begin
         @(negedge clk);
         if (rearm_dc) begin dc_read = 1'b1; rearm_dc = 1'b0; end
         if (rearm_ic) begin ic_read = 1'b1; rearm_ic = 1'b0; end
         if (!busy) idle_cnt++;
         if (dc_resp_valid) begin ndc++; dc_read = 1'b0; rearm_dc = (ndc < 2); end
         if (ic_resp_valid) begin nic++; ic_read = 1'b0; rearm_ic = (nic < 2); end
      end
      dc_read = 1'b0; ic_read = 1'b0;
      chk(ndc == 2 && nic == 2, "contention_count", {ndc[15:0], nic[15:0]}, {16'd2, 16'd2});
      chk(idle_cnt == 3, "contention_idle_cycles", idle_cnt, 3);
      @(negedge clk);
      drain();
      chk_idle("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
